reg_bank_rd: RTL and testbench

Register bank for the multicycle datapath: 32×32-bit storage that receives the write-back word chosen by the write-data mux and serves two registered read ports feeding the A/B operand latches. Reads are synchronous with one-cycle latency. Same-cycle write→read hazards resolve by internal bypass, so the control FSM never inserts a bubble after a write-back.

---
 rtl/reg_bank_rd.sv | 88 ++++++++
 tb/tb_reg_bank_rd.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rd.sv
// 32x32 register bank with two registered read ports, same-edge write bypass,
// a hardwired-zero register and a one-cycle write acknowledge pulse.
module reg_bank_rd #(
    parameter logic [31:0] SP_RESET = 32'd227,
    parameter logic [4:0]  ZERO_REG = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        ReadEn,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic        WriteAck
);

    localparam int SP_INDEX = 29;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic        ack_q, ack_d;
    logic        wr_accept;

    assign wr_accept = RegWrite && (WriteReg != ZERO_REG);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        regs_d = regs_q;
        ack_d  = wr_accept;
        if (wr_accept) begin
            regs_d[WriteReg] = WriteData;
        end
    end

    // The zero check wins over the bypass so a discarded write can never leak.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (ReadEn) begin
            if (ReadReg1 == ZERO_REG) begin
                rd1_d = '0;
            end else if (RegWrite && (WriteReg == ReadReg1)) begin
                rd1_d = WriteData;
            end else begin
                rd1_d = regs_q[ReadReg1];
            end

            if (ReadReg2 == ZERO_REG) begin
                rd2_d = '0;
            end else if (RegWrite && (WriteReg == ReadReg2)) begin
                rd2_d = WriteData;
            end else begin
                rd2_d = regs_q[ReadReg2];
            end
        end
    end

    // NOTE: the storage array itself is reset because the stack pointer must
    // come up at SP_RESET and every other word at zero, not at power-up garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i[4:0]] <= ((i == SP_INDEX) && (ZERO_REG != 5'(SP_INDEX))) ? SP_RESET : '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
            ack_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            regs_q <= regs_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            ack_q  <= ack_d;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign WriteAck  = ack_q;

endmodule

// File: tb/tb_reg_bank_rd.sv
// Bench for reg_bank_rd: directed scenarios followed by random traffic, all
// checked against an array model where reads observe the post-write bank.
module tb_reg_bank_rd;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        ReadEn;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        WriteAck;

    int vectors;
    int miscompares;

    logic [31:0] mdl_mem [32];
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_ack;

    reg_bank_rd dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadEn    (ReadEn),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WriteAck  (WriteAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rd1"}, ReadData1, exp_rd1);
        check({tag, ".rd2"}, ReadData2, exp_rd2);
        check({tag, ".ack"}, {31'd0, WriteAck}, {31'd0, exp_ack});
    endtask

    // Register 0 is never written, so it reads as zero without a special case;
    // a read of a register written at the same edge sees the new word.
    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'd0;
        mdl_mem[29] = 32'd227;
        exp_rd1 = 32'd0;
        exp_rd2 = 32'd0;
        exp_ack = 1'b0;
    endtask

    task automatic cycle(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic ren, input logic [4:0] r1, input logic [4:0] r2);
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
        ReadEn    = ren;
        ReadReg1  = r1;
        ReadReg2  = r2;
        @(posedge clk);
        exp_ack = we && (wr != 5'd0);
        if (exp_ack) mdl_mem[wr] = wd;
        if (ren) begin
            exp_rd1 = mdl_mem[r1];
            exp_rd2 = mdl_mem[r2];
        end
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset between edges with the current inputs still pending.
    task automatic async_reset_pulse(input string tag);
        #1 reset = 1'b0;
        model_reset();
        #1 check_outputs({tag, ".now"});
        @(posedge clk);
        #1 check_outputs({tag, ".held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        RegWrite    = 1'b0;
        WriteReg    = 5'd0;
        WriteData   = 32'd0;
        ReadEn      = 1'b0;
        ReadReg1    = 5'd0;
        ReadReg2    = 5'd0;
        model_reset();

        #2 reset = 1'b0;
        #1 check_outputs("reset_assert");
        repeat (2) @(posedge clk);
        #1 check_outputs("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        cycle("reset_read", 1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd0);
        check("reset_sp", ReadData1, 32'd227);

        cycle("write8", 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cycle("read8", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd29);
        check("read8_val", ReadData1, 32'hDEADBEEF);

        cycle("write0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        cycle("read0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        cycle("write0_bypass", 1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd0, 5'd0);

        cycle("write9", 1'b1, 5'd9, 32'd5, 1'b0, 5'd0, 5'd0);
        cycle("bypass9", 1'b1, 5'd9, 32'd7, 1'b1, 5'd9, 5'd9);
        check("bypass9_val", ReadData2, 32'd7);

        cycle("hold", 1'b1, 5'd9, 32'hFF, 1'b0, 5'd9, 5'd9);
        check("hold_val", ReadData1, 32'd7);
        cycle("unhold", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd8);
        check("unhold_val", ReadData1, 32'hFF);

        cycle("b2b_w1", 1'b1, 5'd4, 32'h1111, 1'b0, 5'd0, 5'd0);
        cycle("b2b_w2", 1'b1, 5'd5, 32'h2222, 1'b1, 5'd4, 5'd5);

        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'hAA;
        ReadEn    = 1'b1;
        ReadReg1  = 5'd3;
        ReadReg2  = 5'd3;
        async_reset_pulse("midreset");
        cycle("post_reset", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd29);
        check("post_reset_sp", ReadData2, 32'd227);
        cycle("post_reset8", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd9);

        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic        ren;
            logic [4:0]  wr;
            logic [4:0]  r1;
            logic [4:0]  r2;
            logic [31:0] wd;
            we  = ($urandom_range(0, 3) != 0);
            ren = ($urandom_range(0, 4) != 0);
            wr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            r1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            r2  = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) r2 = 5'd29;
            wd  = $urandom;
            cycle($sformatf("rand%0d", n), we, wr, wd, ren, r1, r2);
            if ($urandom_range(0, 63) == 0) begin
                RegWrite = 1'b1;
                WriteReg = 5'($urandom);
                async_reset_pulse($sformatf("rand_reset%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
